// File: rtl/exec_unit.sv
// Execute stage: owns AC/E/PC, runs register ops directly and memory-reference
// ops through a single-port synchronous data memory, then pulses o_ex_done.
module exec_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_execute,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [7:0]        i_imm,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  input  logic              i_pc_inc,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic [AWIDTH-1:0] o_pc,
  output logic              o_ex_done,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_MEM_USE, S_MEM_WR, S_DONE, S_RELEASE
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE, OP_ISZ, OP_STORE, OP_LOAD, OP_ADD, OP_BRANCH, OP_CLR_AC,
    OP_CLR_E, OP_COMP_AC, OP_LOAD_AC, OP_CIR_R, OP_CIR_L, OP_INC_AC
  } op_e;

  state_e            state_q;
  op_e               op_q;
  op_e               sel_op;
  logic [DWIDTH-1:0] ac_q;
  logic              e_q;
  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic              mem_ce_q;
  logic              mem_we_q;
  logic              ex_done_q;
  logic              busy_q;

  logic [11:0]       strobes;
  logic              start;
  logic              multi;
  logic [DWIDTH:0]   sum;

  // Vector ordered highest priority first (MSB = isz).
  assign strobes = {i_isz, i_store, i_load, i_add, i_branch, i_clr_ac,
                    i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac};
  assign start   = (state_q == S_IDLE) && i_execute;
  assign multi   = |(strobes & (strobes - 12'd1));
  assign sum     = {1'b0, ac_q} + {1'b0, i_mem_rdata};

  always_comb begin
    // NOTE: default first so every path assigns sel_op and no latch is inferred.
    sel_op = OP_NONE;
    if      (i_isz)     sel_op = OP_ISZ;
    else if (i_store)   sel_op = OP_STORE;
    else if (i_load)    sel_op = OP_LOAD;
    else if (i_add)     sel_op = OP_ADD;
    else if (i_branch)  sel_op = OP_BRANCH;
    else if (i_clr_ac)  sel_op = OP_CLR_AC;
    else if (i_clr_e)   sel_op = OP_CLR_E;
    else if (i_comp_ac) sel_op = OP_COMP_AC;
    else if (i_load_ac) sel_op = OP_LOAD_AC;
    else if (i_cir_r)   sel_op = OP_CIR_R;
    else if (i_cir_l)   sel_op = OP_CIR_L;
    else if (i_inc_ac)  sel_op = OP_INC_AC;
  end

  // NOTE: state uses non-blocking assignments; async reset clears ce/we at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      ac_q        <= '0;
      e_q         <= 1'b0;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      ex_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_pc_inc) pc_q <= pc_q + 1'b1;
          if (start) begin
            op_q   <= sel_op;
            busy_q <= 1'b1;
            case (sel_op)
              OP_ISZ, OP_LOAD, OP_ADD: begin
                mem_ce_q   <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= i_addr;
                state_q    <= S_MEM_RD;
              end
              OP_STORE: begin
                mem_ce_q    <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= i_addr;
                mem_wdata_q <= ac_q;
                state_q     <= S_MEM_WR;
              end
              default: begin
                case (sel_op)
                  OP_BRANCH:  pc_q <= i_addr;
                  OP_CLR_AC:  ac_q <= '0;
                  OP_CLR_E:   e_q  <= 1'b0;
                  OP_COMP_AC: ac_q <= ~ac_q;
                  OP_LOAD_AC: ac_q <= {{(DWIDTH-8){1'b0}}, i_imm};
                  OP_CIR_R:   {ac_q, e_q} <= {e_q, ac_q};
                  OP_CIR_L:   {e_q, ac_q} <= {ac_q, e_q};
                  OP_INC_AC:  ac_q <= ac_q + 1'b1;
                  default:    ;
                endcase
                ex_done_q <= 1'b1;
                state_q   <= S_DONE;
              end
            endcase
          end
        end
        S_MEM_RD: begin
          mem_ce_q <= 1'b0;
          state_q  <= S_MEM_USE;
        end
        S_MEM_USE: begin
          if (op_q == OP_ISZ) begin
            mem_wdata_q <= i_mem_rdata + 1'b1;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= S_MEM_WR;
          end else begin
            if (op_q == OP_ADD)  {e_q, ac_q} <= sum;
            if (op_q == OP_LOAD) ac_q <= i_mem_rdata;
            ex_done_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_MEM_WR: begin
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          // Skip-on-zero: the incremented word is still held in the write register.
          if (op_q == OP_ISZ && mem_wdata_q == '0) pc_q <= pc_q + 1'b1;
          ex_done_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          ex_done_q <= 1'b0;
          state_q   <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!i_execute) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_ce    = mem_ce_q;
  assign o_mem_we    = mem_we_q;
  assign o_ac        = ac_q;
  assign o_e         = e_q;
  assign o_pc        = pc_q;
  assign o_ex_done   = ex_done_q;
  assign o_busy      = busy_q;
  // Flagged during the start cycle itself, while the strobes are still present.
  assign o_err       = start && multi;

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the control unit.
- Consumes the control unit's one-hot op strobes and its execute request, and owns the architectural AC (16b), E (1b) and PC (12b).
- Performs the memory-reference operand accesses on the single-port synchronous data memory, then returns a one-cycle ex_done pulse to the control unit.

Parameters:
- DWIDTH, 16, data/AC width
- AWIDTH, 12, memory address and PC width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_execute  in  1  execute request level from the control unit; sampled only in IDLE
- i_addr  in  AWIDTH  effective operand address, already indirect-resolved
- i_imm  in  8  immediate for load_ac
- i_add, i_load, i_store, i_branch, i_isz  in  1 each  memory-reference op strobes
- i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac  in  1 each  register-reference op strobes
- i_pc_inc  in  1  fetch-stage PC increment; honoured only in IDLE
- i_mem_rdata  in  DWIDTH  memory read data, valid the cycle after a read
- o_mem_addr  out  AWIDTH  memory address
- o_mem_wdata  out  DWIDTH  memory write data
- o_mem_ce  out  1  memory chip enable
- o_mem_we  out  1  memory write enable (1 = write)
- o_ac  out  DWIDTH  accumulator
- o_e  out  1  carry/link bit E
- o_pc  out  AWIDTH  program counter
- o_ex_done  out  1  one-cycle completion pulse
- o_busy  out  1  high in every state except IDLE
- o_err  out  1  one-cycle pulse when more than one op strobe is high at start

Behaviour:
- Reset (async, immediate): AC=0, E=0, PC=0, state=IDLE, all memory outputs 0, o_ex_done=0, o_busy=0, o_err=0.
- Reset asserted mid-operation aborts the op. o_mem_ce and o_mem_we drop in the same cycle; no partial write is retried.
- States: IDLE, MEM_RD, MEM_USE, MEM_WR, DONE, RELEASE.
- Start = IDLE && i_execute. Op strobes, i_addr and i_imm are latched at start.
- Op selection priority: isz > store > load > add > branch > clr_ac > clr_e > comp_ac > load_ac > cir_r > cir_l > inc_ac.
  - More than one strobe high at start: highest priority executes and o_err pulses in the start cycle.
  - No strobe high at start: go to DONE with no state change.
- Register ops and branch: IDLE->DONE. Update at the start edge.
  - clr_ac: AC=0. clr_e: E=0. comp_ac: AC=~AC. load_ac: AC={8'h00,imm}.
  - cir_r: {AC,E} <= {E,AC[15:1],AC[0]}.
  - cir_l: {E,AC} <= {AC[15],AC[14:0],E}.
  - inc_ac: AC=AC+1, wraps FFFF->0000, E unchanged.
  - branch: PC=addr.
- add/load/isz: IDLE->MEM_RD->MEM_USE.
  - MEM_RD drives ce=1, we=0, mem_addr=addr.
  - MEM_USE captures rdata:
    - add: {E,AC}=AC+rdata as a 17-bit sum; E=carry.
    - load: AC=rdata, E unchanged.
    - isz: tmp=rdata+1 (wraps), then MEM_WR.
  - add and load go MEM_USE->DONE.
- isz MEM_WR: ce=1, we=1, wdata=tmp. If tmp==0, PC=PC+1 (wraps FFF->000). Then DONE.
- store: IDLE->MEM_WR with ce=1, we=1, wdata=AC (AC value at start), then DONE.
- ce and we are 0 in all other states.
- DONE: o_ex_done=1 for exactly one cycle, then RELEASE.
- RELEASE: wait until i_execute=0, then IDLE. This prevents re-execution on a held request level.
- Latency (start edge T; o_ex_done high during the listed cycle):
  - register ops and branch: T+1
  - store: T+2
  - add and load: T+3
  - isz: T+4
- i_pc_inc: in IDLE without start, PC=PC+1 (wraps). Ignored in all other states.
  - In IDLE with start and branch, branch wins.
  - In IDLE with start and any other op, PC increments.

Test Plan:
- Reset mid-ISZ (assert reset in MEM_WR) -> ce=0 and we=0 the same cycle; AC/E/PC return to 0; state IDLE; no o_ex_done.
- add: AC=FFFF, mem[0x010]=0002, strobe add at addr 0x010 -> MEM_RD ce=1 we=0 addr=0x010; o_ex_done at T+3; AC=0001, E=1.
- isz: mem[0x020]=FFFF, PC=0x005 -> write of 0000 to 0x020 in MEM_WR; PC=0x006; o_ex_done at T+4. Repeat with mem=0003 -> write 0004; PC unchanged.
- store then load: AC=A5A5, store at 0x0FF -> one write cycle with wdata=A5A5. clr_ac, then load 0x0FF -> AC=A5A5.
- Rotates: AC=8001, E=0; cir_l -> AC=0002, E=1; cir_r -> AC=8001, E=0. inc_ac at AC=FFFF -> AC=0000, E unchanged.
- Handshake/priority: hold i_execute high 10 cycles with clr_e -> exactly one o_ex_done. Start with add+branch strobes -> o_err pulse, add executed, PC unchanged. Branch with i_pc_inc in the same cycle -> PC=addr.
